// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Op sequencing states and the ALU idle opcode.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 4;

  localparam logic [3:0] OP_PASS = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Pure combinational; the caller owns last_grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_any,
  output logic       gnt_id
);

  // a tie goes to the requester that did not win last time
  always_comb begin
    gnt_any = |valid;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): gnt_id = ~last_grant;
      (valid == 2'b10): gnt_id = 1'b1;
      default:          gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the EX stage (req 0) and debug (req 1).
// One op in flight: IDLE -> EXEC -> RESP, flag writes gated.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int FLAG_REQ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_flag_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_error,
  output logic [7:0]        err_cnt
);

  localparam logic [OP_W-1:0] PASS    = OP_W'(OP_PASS);
  localparam logic            FLAG_ID = 1'(FLAG_REQ);

  state_t              state;
  state_t              state_nx;
  logic                last_grant;
  logic                gnt_any;
  logic                gnt_id;
  logic                accept;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                id_q;

  rr_arb2 u_arb (
    .valid      ({r1_valid, r0_valid}),
    .last_grant (last_grant),
    .gnt_any    (gnt_any),
    .gnt_id     (gnt_id)
  );

  assign accept  = (state == IDLE) && gnt_any;
  assign alu_in1 = a_q;
  assign alu_in2 = b_q;

  // next state, handshakes and ALU control
  always_comb begin
    state_nx    = state;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    resp_valid  = 1'b0;
    alu_op      = PASS;
    alu_flag_en = 1'b0;
    unique case (state)
      IDLE: begin
        r0_ready = gnt_any & ~gnt_id;
        r1_ready = gnt_any & gnt_id;
        if (accept) state_nx = EXEC;
      end
      EXEC: begin
        alu_op      = op_q;
        alu_flag_en = (id_q == FLAG_ID) & ~alu_error;
        state_nx    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // capture the granted op; last_grant=1 lets req 0 win the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
    end else if (accept) begin
      last_grant <= gnt_id;
      op_q       <= gnt_id ? r1_op : r0_op;
      a_q        <= gnt_id ? r1_a  : r0_a;
      b_q        <= gnt_id ? r1_b  : r0_b;
      id_q       <= gnt_id;
    end
  end

  // latch the ALU result and count errors at the end of EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
      resp_id   <= 1'b0;
      err_cnt   <= 8'd0;
    end else if (state == EXEC) begin
      resp_data <= alu_out;
      resp_err  <= alu_error;
      resp_id   <= id_q;
      if (alu_error && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// Directed vectors, corner sequences and a random run vs a model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [3:0]  r0_op, r1_op;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_data;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic        alu_flag_en, alu_error;
  logic [7:0]  err_cnt;
  logic        force_err;

  int checks = 0;
  int errors = 0;

  // reference model state (transaction level)
  logic        m_last;
  int          m_errcnt;
  logic        m_busy;
  int          m_age;
  logic        m_id;
  logic [15:0] m_data;
  logic        m_err;

  alu_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .r0_valid    (r0_valid),
    .r0_ready    (r0_ready),
    .r0_op       (r0_op),
    .r0_a        (r0_a),
    .r0_b        (r0_b),
    .r1_valid    (r1_valid),
    .r1_ready    (r1_ready),
    .r1_op       (r1_op),
    .r1_a        (r1_a),
    .r1_b        (r1_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_flag_en (alu_flag_en),
    .alu_out     (alu_out),
    .alu_error   (alu_error),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_out(
    input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd12:   return a;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd12});
  endfunction

  // behavioural ALU attached to the DUT
  always_comb begin
    alu_out   = ref_out(alu_op, alu_in1, alu_in2);
    alu_error = ref_err(alu_op) | force_err;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one op on an idle arbiter; entered and left at a negedge
  task automatic do_op(input logic id, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic ee);
    int n;
    logic rdy;
    if (id) begin
      r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
    end
    #1;
    n = 0;
    rdy = id ? r1_ready : r0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      rdy = id ? r1_ready : r0_ready;
      n++;
    end
    chk("op_accept_now", 32'(n), 32'd0);
    chk("op_other_ready", 32'(id ? r0_ready : r1_ready), 32'd0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk); #1;
    chk("op_flag_en", 32'(alu_flag_en), 32'(!id && !ee));
    chk("op_alu_op", 32'(alu_op), 32'(op));
    chk("op_alu_in1", 32'(alu_in1), 32'(a));
    chk("op_alu_in2", 32'(alu_in2), 32'(b));
    chk("op_resp_early", 32'(resp_valid), 32'd0);
    @(negedge clk); #1;
    m_last = id;
    if (ee && m_errcnt < 255) m_errcnt++;
    chk("op_resp_valid", 32'(resp_valid), 32'd1);
    chk("op_resp_id", 32'(resp_id), 32'(id));
    chk("op_resp_data", 32'(resp_data), 32'(ed));
    chk("op_resp_err", 32'(resp_err), 32'(ee));
    chk("op_err_cnt", 32'(err_cnt), 32'(m_errcnt));
    chk("op_flag_resp", 32'(alu_flag_en), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int acc_cyc[$];
    logic acc_id[$];
    logic e0, e1, p0, p1, quiet;

    vecs[0] = '{1'b0, 4'd0,  16'h0003, 16'h0004, 16'h0007, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 4'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[3] = '{1'b1, 4'd2,  16'h00FF, 16'h00FF, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 4'd3,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[5] = '{1'b1, 4'd4,  16'hF000, 16'h000F, 16'hF00F, 1'b0};
    vecs[6] = '{1'b0, 4'd12, 16'h1234, 16'h5678, 16'h1234, 1'b0};
    vecs[7] = '{1'b1, 4'd5,  16'h0001, 16'h0001, 16'h0000, 1'b1};
    vecs[8] = '{1'b0, 4'd15, 16'hAAAA, 16'h5555, 16'h0000, 1'b1};

    rst = 1'b0;
    force_err = 1'b0;
    r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
    r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;
    resp_ready = 1'b0;
    m_last = 1'b1; m_errcnt = 0; m_busy = 1'b0; m_age = 0;
    m_id = 1'b0; m_data = '0; m_err = 1'b0;

    // reset values
    @(negedge clk); @(negedge clk); #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'hC);
    chk("rst_flag_en", 32'(alu_flag_en), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed vectors (first one is the basic ADD latency case)
    for (int i = 0; i < 9; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].ed, vecs[i].ee);

    // response stall: nothing accepted while RESP is held
    r0_valid = 1'b1; r0_op = 4'd0; r0_a = 16'd5; r0_b = 16'd6;
    #1 chk("stall_accept", 32'(r0_ready), 32'd1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_op = 4'd2; r1_a = 16'hF0F0; r1_b = 16'h0FF0;
    @(negedge clk); #1;
    chk("stall_exec_r1", 32'(r1_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", 32'(resp_data), 32'd11);
      chk("stall_rdy", 32'({r0_ready, r1_ready}), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk); #1;
    chk("stall_resume", 32'(r1_ready), 32'd1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    @(negedge clk); #1;
    chk("stall_r1_flag", 32'(alu_flag_en), 32'd0);
    @(negedge clk); #1;
    chk("stall_r1_data", 32'(resp_data), 32'hFF00);
    chk("stall_r1_id", 32'(resp_id), 32'd1);
    m_last = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);

    // both requesting every cycle: alternating grants every 3 cycles
    r0_valid = 1'b1; r0_op = 4'd0; r0_a = 16'd1; r0_b = 16'd2;
    r1_valid = 1'b1; r1_op = 4'd0; r1_a = 16'd3; r1_b = 16'd4;
    resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("alt_both_ready", 32'(r0_ready & r1_ready), 32'd0);
      if (r0_ready || r1_ready) begin
        acc_cyc.push_back(c);
        acc_id.push_back(r1_ready);
      end
      @(negedge clk);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (4) @(negedge clk);
    resp_ready = 1'b0;
    chk("alt_count", 32'(acc_cyc.size()), 32'd4);
    if (acc_cyc.size() == 4) begin
      chk("alt_first_id", 32'(acc_id[0]), 32'(!m_last));
      chk("alt_first_cyc", 32'(acc_cyc[0]), 32'd0);
      for (int i = 1; i < 4; i++) begin
        chk("alt_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        chk("alt_id", 32'(acc_id[i]), 32'(!acc_id[i-1]));
      end
      m_last = acc_id[3];
    end

    // random traffic against the transaction model
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      quiet = (c >= 1490);
      #1;
      e0 = !m_busy && r0_valid && (!r1_valid || m_last);
      e1 = !m_busy && r1_valid && (!r0_valid || !m_last);
      chk("rnd_r0_ready", 32'(r0_ready), 32'(e0));
      chk("rnd_r1_ready", 32'(r1_ready), 32'(e1));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(m_busy && m_age == 2));
      if (m_busy && m_age == 2) begin
        chk("rnd_resp_id", 32'(resp_id), 32'(m_id));
        chk("rnd_resp_data", 32'(resp_data), 32'(m_data));
        chk("rnd_resp_err", 32'(resp_err), 32'(m_err));
      end
      chk("rnd_flag_en", 32'(alu_flag_en),
          32'(m_busy && m_age == 1 && !m_id && !m_err));
      chk("rnd_err_cnt", 32'(err_cnt), 32'(m_errcnt));
      @(posedge clk);
      if (!m_busy) begin
        if (e0 || e1) begin
          m_busy = 1'b1;
          m_age  = 1;
          m_id   = e1;
          m_data = e1 ? ref_out(r1_op, r1_a, r1_b) : ref_out(r0_op, r0_a, r0_b);
          m_err  = e1 ? ref_err(r1_op) : ref_err(r0_op);
          m_last = e1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
        if (m_err && m_errcnt < 255) m_errcnt++;
      end else if (resp_ready) begin
        m_busy = 1'b0;
      end
      if (e0) p0 = 1'b0;
      if (e1) p1 = 1'b0;
      #1;
      if (!p0 && !quiet && $urandom_range(2) == 0) begin
        p0 = 1'b1;
        r0_op = 4'($urandom); r0_a = 16'($urandom); r0_b = 16'($urandom);
      end
      if (!p1 && !quiet && $urandom_range(2) == 0) begin
        p1 = 1'b1;
        r1_op = 4'($urandom); r1_a = 16'($urandom); r1_b = 16'($urandom);
      end
      r0_valid = p0 && !quiet && ($urandom_range(15) != 0);
      r1_valid = p1 && !quiet && ($urandom_range(15) != 0);
      resp_ready = quiet ? 1'b1 : 1'($urandom_range(1));
      @(negedge clk);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);

    // forced ALU error on the flag-owning requester
    force_err = 1'b1;
    do_op(1'b0, 4'd0, 16'd1, 16'd1, 16'd2, 1'b1);
    force_err = 1'b0;

    // error counter saturation
    for (int i = 0; i < 300; i++)
      do_op(1'(i), 4'hF, 16'(i), 16'(i), 16'h0000, 1'b1);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    // reset during EXEC discards the op
    r0_valid = 1'b1; r0_op = 4'd0; r0_a = 16'd2; r0_b = 16'd2;
    #1 chk("mid_accept", 32'(r0_ready), 32'd1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk); #1;
    chk("mid_flag_before", 32'(alu_flag_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_flag_after", 32'(alu_flag_en), 32'd0);
    chk("mid_alu_op", 32'(alu_op), 32'hC);
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_alu_in1", 32'(alu_in1), 32'd0);
    m_errcnt = 0;
    m_last = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    do_op(1'b0, 4'd0, 16'd2, 16'd3, 16'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
